// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start/data/stop sampling FSM,
// first-word-fall-through receive FIFO and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  input  logic                 rd_en_i,
  input  logic                 clr_err_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 full_o,
  output logic                 busy_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  // Input synchronizer; both flops idle high so reset looks like a quiet line.
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   push;
  logic                   ferr_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        // Sampling at the full-bit count lands mid-bit because START ended mid-bit.
        if (cnt_q == CNT_LAST) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop     = rd_en_i && !empty;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop     ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Sticky error flags; a new error in the clearing cycle must not be lost.
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clr_err_i) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (ferr_set) begin
      frame_err_d = 1'b1;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_o      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign valid_o     = !empty;
  assign full_o      = full;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit and a 4-entry FIFO: table vectors,
// hand-written corner sequences and random frames against a queue model.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_i = 1'b1;
  logic       rd_en_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, full_o, busy_o, frame_err_o, overrun_o;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_i(rx_i), .rd_en_i(rd_en_i), .clr_err_i(clr_err_i),
    .data_o(data_o), .valid_o(valid_o), .full_o(full_o), .busy_o(busy_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting at the current cycle; k counts edges since the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int pop_at,
                            input int abort_at, output logic v154, output logic v155,
                            output logic [7:0] d155, output logic [7:0] popped);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    v154 = 1'b0; v155 = 1'b0; d155 = '0; popped = '0;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_at) return;
      rx_i = bits[c / CPB];
      rd_en_i = (c == pop_at);
      if (c == pop_at) popped = data_o;
      cyc(1);
      if (c + 1 == 154) v154 = valid_o;
      if (c + 1 == 155) begin
        v155 = valid_o;
        d155 = data_o;
      end
    end
    rx_i = 1'b1;
    rd_en_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic stopb);
    logic a, b;
    logic [7:0] x, y;
    send_frame(d, stopb, -1, -1, a, b, x, y);
    cyc(CPB);
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk({nm, " valid"}, valid_o, 1);
    chk({nm, " data"}, data_o, exp);
    rd_en_i = 1'b1;
    cyc(1);
    rd_en_i = 1'b0;
  endtask

  task automatic clr_err();
    clr_err_i = 1'b1;
    cyc(1);
    clr_err_i = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " valid"}, valid_o, 0);
    chk({nm, " full"}, full_o, 0);
    chk({nm, " busy"}, busy_o, 0);
    chk({nm, " ferr"}, frame_err_o, 0);
    chk({nm, " ovr"}, overrun_o, 0);
    chk({nm, " data"}, data_o, 0);
  endtask

  vec_t       tbl[6];
  logic       v154, v155;
  logic [7:0] d155, popped;
  logic [7:0] q[$];
  logic       m_ferr, m_ovr;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h5A, 1'b1, 1'b1, 1'b0};

    cyc(3);
    chk_reset_outs("reset");
    reset = 1'b1;
    cyc(5);

    // Table vectors: each frame alone in an empty FIFO, 155-cycle latency.
    foreach (tbl[i]) begin
      clr_err();
      cyc(2);
      send_frame(tbl[i].data, tbl[i].stopb, -1, -1, v154, v155, d155, popped);
      chk("tbl valid@154", v154, 0);
      chk("tbl valid@155", v155, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl data@155", d155, tbl[i].data);
      cyc(CPB);
      chk("tbl ferr", frame_err_o, tbl[i].exp_ferr);
      chk("tbl busy idle", busy_o, 0);
      if (tbl[i].exp_valid) begin
        pop_chk("tbl pop", tbl[i].data);
        chk("tbl valid after pop", valid_o, 0);
      end
    end
    clr_err();

    // Glitch rejection.
    rx_i = 1'b0;
    cyc(3);
    rx_i = 1'b1;
    cyc(1);
    chk("glitch busy", busy_o, 1);
    cyc(16);
    chk("glitch busy back", busy_o, 0);
    chk("glitch valid", valid_o, 0);
    chk("glitch ferr", frame_err_o, 0);
    chk("glitch ovr", overrun_o, 0);

    // Framing error followed by a long break, then a clean frame.
    send_frame(8'h3C, 1'b0, -1, -1, v154, v155, d155, popped);
    rx_i = 1'b0;
    cyc(40);
    chk("break busy", busy_o, 1);
    chk("break ferr", frame_err_o, 1);
    chk("break valid", valid_o, 0);
    rx_i = 1'b1;
    cyc(CPB);
    chk("break idle", busy_o, 0);
    chk("break still empty", valid_o, 0);
    send(8'h55, 1'b1);
    chk("after break ferr sticky", frame_err_o, 1);
    pop_chk("after break", 8'h55);
    clr_err();
    chk("ferr cleared", frame_err_o, 0);

    // Fill and overrun.
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      if (i == 3) chk("fill full@3", full_o, 0);
      if (i == 4) chk("fill full@4", full_o, 1);
      if (i == 4) chk("fill ovr@4", overrun_o, 0);
    end
    chk("fill ovr@5", overrun_o, 1);
    for (int i = 1; i <= 4; i++) pop_chk("fill pop", 8'(i));
    chk("fill drained", valid_o, 0);
    clr_err();
    chk("ovr cleared", overrun_o, 0);

    // Full FIFO with pop on the stop-sample edge, through pointer wrap.
    q.delete();
    for (int i = 1; i <= 4; i++) begin
      send(8'h10 + 8'(i), 1'b1);
      q.push_back(8'h10 + 8'(i));
    end
    for (int i = 5; i <= 10; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1, 154, -1, v154, v155, d155, popped);
      chk("wrap popped", popped, q.pop_front());
      q.push_back(8'h10 + 8'(i));
      cyc(CPB);
      chk("wrap ovr", overrun_o, 0);
      chk("wrap full", full_o, 1);
    end
    while (q.size() > 0) pop_chk("wrap drain", q.pop_front());
    chk("wrap empty", valid_o, 0);

    // Reset during data bit 4 with two bytes buffered.
    send(8'hC3, 1'b1);
    send(8'h3C, 1'b1);
    send_frame(8'h99, 1'b1, -1, 5 * CPB + 8, v154, v155, d155, popped);
    chk("pre-reset busy", busy_o, 1);
    rx_i = 1'b1;
    reset = 1'b0;
    #1;
    chk_reset_outs("midreset");
    cyc(3);
    reset = 1'b1;
    cyc(3);
    chk_reset_outs("post reset");
    send(8'h7E, 1'b1);
    pop_chk("post reset rx", 8'h7E);
    chk("post reset single", valid_o, 0);
    chk("post reset ferr", frame_err_o, 0);

    // Random frames against a queue model of the FIFO and flags.
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       s;
      int         npop;
      npop = int'($urandom_range(0, 2));
      for (int p = 0; p < npop; p++) begin
        if (q.size() > 0) pop_chk("rnd pop", q.pop_front());
        else begin
          chk("rnd empty", valid_o, 0);
          rd_en_i = 1'b1;
          cyc(1);
          rd_en_i = 1'b0;
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_err();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      d = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      send(d, s);
      if (!s) m_ferr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(d);
      else m_ovr = 1'b1;
      chk("rnd valid", valid_o, (q.size() > 0));
      chk("rnd full", full_o, (q.size() == DEPTH));
      chk("rnd ferr", frame_err_o, m_ferr);
      chk("rnd ovr", overrun_o, m_ovr);
      if (q.size() > 0) chk("rnd head", data_o, q[0]);
    end
    while (q.size() > 0) pop_chk("rnd drain", q.pop_front());
    chk("rnd final empty", valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
